// File: rtl/ysyx_22050612_pkg.sv
// Shared encodings and default widths for the memory arbiter slice.
package ysyx_22050612_pkg;
  localparam int DEF_ADDR_W     = 64;
  localparam int DEF_DATA_W     = 64;
  localparam int DEF_STARVE_MAX = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_t;
endpackage

// File: rtl/ysyx_22050612_arb_prio.sv
// Two-way LSU-first pick with a saturating counter that forces an IFU win
// after STARVE_MAX consecutive LSU wins over a pending IFU request.
module ysyx_22050612_arb_prio #(
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = $clog2(STARVE_MAX + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic arb_en,
  input  logic if_valid,
  input  logic ls_valid,
  output logic grant_if,
  output logic grant_ls
);
  logic [CNT_W-1:0] starve_cnt;
  logic             at_max;

  assign at_max   = (starve_cnt == CNT_W'(STARVE_MAX));
  assign grant_if = arb_en && if_valid && (!ls_valid || at_max);
  assign grant_ls = arb_en && ls_valid && !(if_valid && at_max);

  // Counter moves only on grants; LSU wins with no IFU waiting do not count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (grant_if) begin
      starve_cnt <= '0;
    end else if (grant_ls && if_valid && !at_max) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end
endmodule

// File: rtl/ysyx_22050612_mem_arbiter.sv
// Shares one memory port between IFU and LSU, one outstanding transaction
// at a time; LSU has priority, bounded by the starvation counter.
module ysyx_22050612_mem_arbiter
  import ysyx_22050612_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req_valid,
  output logic                if_req_ready,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_resp_valid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                ls_req_valid,
  output logic                ls_req_ready,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic                ls_wen,
  input  logic [DATA_W-1:0]   ls_wdata,
  input  logic [DATA_W/8-1:0] ls_wmask,
  output logic                ls_resp_valid,
  output logic [DATA_W-1:0]   ls_rdata,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_rdata
);
  state_t state;
  owner_t owner;
  logic   arb_en;
  logic   grant_if;
  logic   grant_ls;
  logic   resp_hit;

  // Gating with rst_n keeps the ready outputs low while reset is held.
  assign arb_en = (state == IDLE) && rst_n;

  ysyx_22050612_arb_prio #(
    .STARVE_MAX (STARVE_MAX)
  ) u_prio (
    .clk      (clk),
    .rst_n    (rst_n),
    .arb_en   (arb_en),
    .if_valid (if_req_valid),
    .ls_valid (ls_req_valid),
    .grant_if (grant_if),
    .grant_ls (grant_ls)
  );

  assign if_req_ready = grant_if;
  assign ls_req_ready = grant_ls;

  assign resp_hit      = (state == WAIT) && mem_resp_valid;
  assign if_resp_valid = resp_hit && (owner == OWN_IF);
  assign ls_resp_valid = resp_hit && (owner == OWN_LS);
  assign if_rdata      = if_resp_valid ? mem_rdata : '0;
  assign ls_rdata      = ls_resp_valid ? mem_rdata : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      owner         <= OWN_IF;
      mem_req_valid <= 1'b0;
      mem_addr      <= '0;
      mem_wen       <= 1'b0;
      mem_wdata     <= '0;
      mem_wmask     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_if || grant_ls) begin
            owner         <= grant_ls ? OWN_LS : OWN_IF;
            mem_addr      <= grant_ls ? ls_addr : if_addr;
            mem_wen       <= grant_ls && ls_wen;
            mem_wdata     <= grant_ls ? ls_wdata : '0;
            mem_wmask     <= grant_ls ? ls_wmask : '0;
            mem_req_valid <= 1'b1;
            state         <= REQ;
          end
        end
        REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= WAIT;
          end
        end
        WAIT: begin
          if (mem_resp_valid) begin
            state <= IDLE;
          end
        end
        default: begin
          state         <= IDLE;
          mem_req_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: doc/ysyx_22050612_mem_arbiter.md
Name: ysyx_22050612_mem_arbiter

Overview:
- Shares the core's single memory port between the instruction-fetch unit (IFU) and the load/store unit (LSU).
- Sits between IFU/LSU and the memory/bus model, which is reached through DPI in simulation.
- Allows one outstanding transaction at a time, using valid/ready request handshakes and valid-only responses.
- LSU has fixed priority; an anti-starvation counter guarantees IFU progress.

Parameters:
ADDR_W, 64, address width
DATA_W, 64, data width; mask width is DATA_W/8
STARVE_MAX, 4, number of consecutive LSU wins against a pending IFU request before IFU is forced to win (>=1)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous, active-low reset
if_req_valid  in  1  IFU read request
if_req_ready  out  1  IFU request accepted this cycle
if_addr  in  ADDR_W  IFU fetch address
if_resp_valid  out  1  IFU read data valid (1-cycle pulse)
if_rdata  out  DATA_W  IFU read data
ls_req_valid  in  1  LSU request
ls_req_ready  out  1  LSU request accepted this cycle
ls_addr  in  ADDR_W  LSU address
ls_wen  in  1  1 = write, 0 = read
ls_wdata  in  DATA_W  store data
ls_wmask  in  DATA_W/8  byte-enable mask for stores
ls_resp_valid  out  1  LSU response (read data or write ack), 1-cycle pulse
ls_rdata  out  DATA_W  LSU read data
mem_req_valid  out  1  request to memory
mem_req_ready  in  1  memory accepts request
mem_addr  out  ADDR_W  registered address
mem_wen  out  1  registered write enable
mem_wdata  out  DATA_W  registered store data
mem_wmask  out  DATA_W/8  registered mask
mem_resp_valid  in  1  memory response valid
mem_rdata  in  DATA_W  memory read data

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE, owner=IF, starve_cnt=0.
  - All outputs are 0, including the mem_addr/wdata/wmask/wen registers.
  - Reset mid-transaction abandons the transaction; no response pulse is produced.
- FSM states: IDLE, REQ, WAIT.
- IDLE arbitration (combinational, same cycle):
  - Only ls valid -> grant LS.
  - Only if valid -> grant IF.
  - Both valid -> grant IF if starve_cnt==STARVE_MAX, else grant LS.
  - The granted requester sees xx_req_ready=1 for exactly that cycle; the other sees ready=0.
  - On the clock edge: latch addr/wen/wdata/wmask and owner, then go to REQ.
  - IF grants latch wen=0 and wmask=0.
- starve_cnt:
  - Updated only on IDLE grants.
  - LS granted while if_req_valid=1 -> increment, saturating at STARVE_MAX.
  - IF granted -> clear to 0.
  - LS granted with if_req_valid=0 -> unchanged.
- REQ:
  - mem_req_valid=1; outputs stay stable until mem_req_ready=1.
  - mem_req_ready=1 -> go to WAIT.
  - The response may not arrive in the same cycle as acceptance; such a response is ignored.
- WAIT:
  - mem_resp_valid=1 -> owner's xx_resp_valid=1 combinationally in that cycle, with xx_rdata=mem_rdata; then go to IDLE.
  - Non-owner resp_valid stays 0.
  - Non-owner rdata is don't-care; it is driven 0.
- mem_resp_valid outside WAIT is ignored.
- All req_ready outputs are 0 in REQ and WAIT. Requesters must hold valid and payload until ready.
- Minimum latency, accept to response: 2 cycles (accept edge -> REQ with ready=1 -> WAIT with resp=1).
- Next arbitration happens in the cycle after the response; there is no bubble beyond the return to IDLE.
- Any mem_req_ready/mem_resp_valid stall length is legal; there is no timeout.
- Store responses raise ls_resp_valid as a write ack; ls_rdata carries whatever mem_rdata holds.

Decomposition:
- Shared package ysyx_22050612_pkg holds:
  - the state encoding (IDLE=2'd0, REQ=2'd1, WAIT=2'd2);
  - owner encoding (OWN_IF=1'b0, OWN_LS=1'b1);
  - default widths.
- Natural sub-module: ysyx_22050612_arb_prio, a combinational 2-way priority pick plus the saturating starve counter with grant outputs.
- FSM and payload registers stay in the top module.

Test Plan:
1. IF read only:
   - Stimulus: if_req_valid=1, if_addr=0x80000000; mem_req_ready=1 in REQ; mem_resp_valid=1 next cycle with rdata=0x00100073.
   - Required: if_req_ready pulse at cycle 0, mem_addr=0x80000000, if_resp_valid pulse with if_rdata=0x00100073 at cycle 2; ls_resp_valid stays 0.
2. LS store:
   - Stimulus: ls_wen=1, addr=0x80001000, wdata=0xDEADBEEF, wmask=0x0F.
   - Required: mem_wen=1, mem_wmask=0x0F, mem_wdata=0xDEADBEEF held through a 3-cycle mem_req_ready stall; ls_resp_valid pulses once.
3. Both valid continuously, STARVE_MAX=4, memory with 0 stall:
   - Required: grant sequence LS,LS,LS,LS,IF,LS,LS,LS,LS,IF; starve_cnt reads 0 after each IF grant.
4. Reset mid-transaction:
   - Stimulus: rst_n=0 while in WAIT.
   - Required: all outputs drop to 0 asynchronously. After release, a late mem_resp_valid=1 produces no resp pulse, and the next if request is granted normally.
5. Stray responses:
   - Stimulus: mem_resp_valid=1 in IDLE and in REQ.
   - Required: no if/ls_resp_valid; state unchanged.
6. Back-to-back LS reads, addr 0x10 then 0x18:
   - Required: second ls_req_ready is asserted the cycle after the first ls_resp_valid, and mem_addr updates to 0x18.
